// File: rtl/rf_wb_scheduler_pkg.sv
// Shared types and constants for the register-file writeback scheduler.
package rf_wb_scheduler_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned WB_DATA_W = 32;

  localparam logic [REG_IDX_W-1:0] X0 = '0;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic is_x0(input logic [REG_IDX_W-1:0] idx);
    return idx == X0;
  endfunction

endpackage

// File: rtl/rf_busy_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, x0 never busy.
module rf_busy_scoreboard
  import rf_wb_scheduler_pkg::*;
#(
  parameter int unsigned NREGS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_set_en,
  input  logic [REG_IDX_W-1:0] i_set_idx,
  input  logic                 i_clr_en,
  input  logic [REG_IDX_W-1:0] i_clr_idx,
  input  logic [REG_IDX_W-1:0] i_rs1,
  input  logic [REG_IDX_W-1:0] i_rs2,
  output logic                 o_busy_rs1,
  output logic                 o_busy_rs2
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;

  // Clear is applied before set so a same-cycle reissue of rd stays pending.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_en) w_busy_nxt[i_clr_idx] = 1'b0;
    if (i_set_en && !is_x0(i_set_idx)) w_busy_nxt[i_set_idx] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_busy_rs1 = r_busy[i_rs1];
  assign o_busy_rs2 = r_busy[i_rs2];

endmodule

// File: rtl/rf_wb_scheduler.sv
// Arbitrates ALU/MEM writebacks onto the single register-file write port.
// Optional macro RR_ARB_EN selects round-robin instead of fixed MEM>ALU priority.
module rf_wb_scheduler
  import rf_wb_scheduler_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [N-1:0]         alu_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [REG_IDX_W-1:0] mem_rd,
  input  logic [N-1:0]         mem_data,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  output logic                 busy_rs1,
  output logic                 busy_rs2,
  output logic                 regwrite,
  output logic [REG_IDX_W-1:0] write_reg,
  output logic [N-1:0]         write_data
);

  wb_req_t w_alu_req;
  wb_req_t w_mem_req;
  wb_req_t w_sel;
  logic    w_gnt_alu;
  logic    w_gnt_mem;
  logic    w_any_gnt;

  logic                 r_regwrite;
  logic [REG_IDX_W-1:0] r_write_reg;
  logic [N-1:0]         r_write_data;

  assign w_alu_req = '{valid: alu_valid, rd: alu_rd, data: WB_DATA_W'(alu_data)};
  assign w_mem_req = '{valid: mem_valid, rd: mem_rd, data: WB_DATA_W'(mem_data)};

`ifdef RR_ARB_EN
  req_e r_last;

  always_comb begin
    w_gnt_alu = 1'b0;
    w_gnt_mem = 1'b0;
    if (w_alu_req.valid && w_mem_req.valid) begin
      w_gnt_mem = (r_last == REQ_ALU);
      w_gnt_alu = (r_last == REQ_MEM);
    end else begin
      w_gnt_mem = w_mem_req.valid;
      w_gnt_alu = w_alu_req.valid;
    end
  end

  // Pointer only moves on contested grants; uncontested traffic leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= REQ_ALU;
    end else if (w_alu_req.valid && w_mem_req.valid) begin
      r_last <= w_gnt_mem ? REQ_MEM : REQ_ALU;
    end
  end
`else
  always_comb begin
    w_gnt_mem = w_mem_req.valid;
    w_gnt_alu = w_alu_req.valid && !w_mem_req.valid;
  end
`endif

  assign alu_ready = w_gnt_alu;
  assign mem_ready = w_gnt_mem;
  assign w_any_gnt = w_gnt_alu || w_gnt_mem;
  assign w_sel     = w_gnt_mem ? w_mem_req : w_alu_req;

  // An accepted x0 request is treated like an idle cycle at the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regwrite   <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else begin
      r_regwrite <= w_any_gnt && !is_x0(w_sel.rd);
      if (w_any_gnt && !is_x0(w_sel.rd)) begin
        r_write_reg  <= w_sel.rd;
        r_write_data <= N'(w_sel.data);
      end
    end
  end

  assign regwrite   = r_regwrite;
  assign write_reg  = r_write_reg;
  assign write_data = r_write_data;

  rf_busy_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .i_set_en   (issue_valid),
    .i_set_idx  (issue_rd),
    .i_clr_en   (w_any_gnt),
    .i_clr_idx  (w_sel.rd),
    .i_rs1      (rs1),
    .i_rs2      (rs2),
    .o_busy_rs1 (busy_rs1),
    .o_busy_rs2 (busy_rs2)
  );

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Shares the single register-file write port between two writeback requesters: ALU/execute (ALU) and load/memory (MEM).
- Tracks which destination registers have a pending write in a busy scoreboard, so decode can stall on RAW hazards.
- Sits between the execute/memory stages and reg_file; drives regwrite/write_reg/write_data through one output register stage.

Parameters:
N, 32, data width of the write data and register contents
NREGS, 32, number of architectural registers; the rd/rs index width is 5 bits (fixed)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU request accepted this cycle
alu_rd  in  5  ALU destination register
alu_data  in  N  ALU result
mem_valid  in  1  MEM writeback request
mem_ready  out  1  MEM request accepted this cycle
mem_rd  in  5  MEM destination register
mem_data  in  N  load data
issue_valid  in  1  decode issues an instruction that writes a register
issue_rd  in  5  destination register of the issued instruction
rs1  in  5  decode source register 1 query
rs2  in  5  decode source register 2 query
busy_rs1  out  1  rs1 has a pending write
busy_rs2  out  1  rs2 has a pending write
regwrite  out  1  to reg_file regwrite
write_reg  out  5  to reg_file write_reg
write_data  out  N  to reg_file write_data

Behaviour:
- Reset (async, rst=1): regwrite=0, write_reg=0, write_data=0, all busy bits=0, round-robin pointer=ALU.
- Handshake: a transfer happens when valid&&ready in the same cycle. A requester holds valid, rd and data stable until ready. ready is combinational from the grant; at most one ready is high per cycle. A ready never asserts without the matching valid.
- Arbitration default is fixed priority: MEM wins over ALU. A losing requester sees ready=0 and retries the next cycle.
- Output stage: the granted request is registered; regwrite/write_reg/write_data are valid the cycle after the handshake (latency 1).
  - With no grant, regwrite=0 next cycle; write_reg and write_data hold their last values.
  - The write port never blocks, so throughput is 1 write per cycle.
- x0: a request with rd=0 is accepted and consumed, but regwrite stays 0 for it.
- Scoreboard (busy[NREGS-1:0], busy[0] hard-wired 0):
  - Set: issue_valid with issue_rd!=0 sets busy[issue_rd] at the clock edge.
  - Clear: an accepted request clears busy[rd] at the same edge as the handshake, not the output edge.
  - Set and clear of the same register in one cycle: set wins (a newer write is now pending).
  - busy_rs1 = busy[rs1] and busy_rs2 = busy[rs2], combinational from the current register state; no same-cycle bypass of a clear.
- A writeback to a non-busy register is legal: the write is performed and busy stays 0.
- Reset mid-operation: any in-flight output write and all pending busy bits are discarded immediately.

Optional Feature:
- Macro RR_ARB_EN.
- Defined: round-robin arbitration. When both requesters are valid, the one not granted last wins. The pointer updates only on a contested grant and resets to favour ALU.
- Undefined: fixed MEM>ALU priority as above; the pointer logic is not compiled.

Decomposition:
- Shared package holds:
  - REG_IDX_W=5 and the X0 constant.
  - The requester encoding REQ_ALU=0, REQ_MEM=1.
  - The writeback request struct {valid, rd, data}.
- One natural sub-module, rf_busy_scoreboard: the busy vector with set/clear/query.
- The arbiter and output register stay in the top.

Test Plan:
- Reset, then ALU-only request (rd=5, data=0xDEADBEEF): alu_ready=1 same cycle; next cycle regwrite=1, write_reg=5, write_data=0xDEADBEEF.
- ALU (rd=3) and MEM (rd=4) valid together, fixed priority: cycle 0 mem_ready=1 and alu_ready=0; cycle 1 writes x4 and grants ALU; cycle 2 writes x3.
- With RR_ARB_EN, both requesters valid for 4 cycles: grants alternate MEM, ALU, MEM, ALU (pointer starts at ALU, so the first contested grant goes to MEM); outputs follow 1 cycle later.
- issue_valid rd=7, then rs1=7: busy_rs1=1 next cycle. MEM write rd=7: busy_rs1=0 the cycle after the handshake. The same cycle's issue_rd=7 keeps it 1 (set wins).
- Request with rd=0, data=0x1234: ready=1, regwrite stays 0. issue_rd=0 never sets busy; rs1=0 always reads busy_rs1=0.
- Set busy on x1 to x3, start a write, then assert rst mid-cycle: regwrite, write_reg and busy_rs* drop to 0 immediately without waiting for clk.
